seg7_scan_rx: RTL and testbench

- Receiving end of the team's 4-digit multiplexed 7-segment display bus.
- Monitors the active-low segment lines a..g and the one-hot digit strobes A1..A4, and decodes each segment pattern back to a BCD value.
- Outputs the four digits atomically, once per complete, well-ordered scan.
- Used as a display loopback checker and as the input stage for boards that take a scanned display bus.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg7_scan_rx.sv | 167 ++++++++++++++++
 tb/tb_seg7_scan_rx.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the scanned 7-segment receive path: segment patterns,
// error cause codes and the frame assembler states.
package seg7_pkg;

  // Active-low patterns, packed as {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PATTERN = 2'b01;
  localparam logic [1:0] ERR_ORDER   = 2'b10;
  localparam logic [1:0] ERR_MULTI   = 2'b11;

  typedef enum logic {HUNT, CAP} state_t;

  // Digit position of a one-hot strobe; meaningless for other values.
  function automatic logic [1:0] strb_index(input logic [3:0] s);
    case (s)
      4'b0010: strb_index = 2'd1;
      4'b0100: strb_index = 2'd2;
      4'b1000: strb_index = 2'd3;
      default: strb_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Inverse of the BCD segment encoder: active-low 7-bit pattern to
// {valid, digit}. Any pattern outside the ten glyphs is flagged invalid.
module seg7_to_bcd
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic       o_valid,
  output logic [3:0] o_val
);

  always_comb begin
    o_valid = 1'b1;
    o_val   = 4'd0;
    case (i_pat)
      SEG_0:   o_val = 4'd0;
      SEG_1:   o_val = 4'd1;
      SEG_2:   o_val = 4'd2;
      SEG_3:   o_val = 4'd3;
      SEG_4:   o_val = 4'd4;
      SEG_5:   o_val = 4'd5;
      SEG_6:   o_val = 4'd6;
      SEG_7:   o_val = 4'd7;
      SEG_8:   o_val = 4'd8;
      SEG_9:   o_val = 4'd9;
      default: o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_rx.sv
// Receiver for a 4-digit multiplexed 7-segment bus: synchronises the lines,
// samples each settled digit once per dwell and publishes whole frames only.
module seg7_scan_rx
  import seg7_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SETTLE      = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       A1,
  input  logic       A2,
  input  logic       A3,
  input  logic       A4,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [1:0] err_code
);

  localparam logic [3:0] SETTLE_C = 4'(SETTLE);

  logic [10:0] r_sync [SYNC_STAGES];
  logic [3:0]  w_strb;
  logic [6:0]  w_pat;

  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [3:0]  r_prev_strb;
  logic [3:0]  r_dwell_strb;
  logic        r_sampled;
  logic        w_new_dwell;
  logic        w_sample;

  logic        w_pat_ok;
  logic [3:0]  w_val;
  logic        w_multi;
  logic        w_is_a1;
  logic [1:0]  w_idx;

  state_t      r_state;
  logic [1:0]  r_k;
  logic [3:0]  r_shadow [4];

  // Stage: input synchroniser, strobes and segments travel together
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {A4, A3, A2, A1, g, f, e, d, c, b, a};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_strb = r_sync[SYNC_STAGES-1][10:7];
  assign w_pat  = r_sync[SYNC_STAGES-1][6:0];

  // Blanking clears the run length but keeps the dwell, so a strobe that
  // returns after a blank gap is not sampled a second time.
  always_comb begin
    w_cnt_nxt = 4'd0;
    if (w_strb == 4'd0)
      w_cnt_nxt = 4'd0;
    else if (w_strb == r_prev_strb)
      w_cnt_nxt = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;
    else
      w_cnt_nxt = 4'd1;
  end

  assign w_new_dwell = (w_strb != 4'd0) && (w_strb != r_dwell_strb);
  assign w_sample    = (w_strb != 4'd0) && (w_cnt_nxt == SETTLE_C) &&
                       (w_new_dwell || !r_sampled);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt        <= 4'd0;
      r_prev_strb  <= 4'd0;
      r_dwell_strb <= 4'd0;
      r_sampled    <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_prev_strb <= w_strb;
      if (w_new_dwell) begin
        r_dwell_strb <= w_strb;
        r_sampled    <= w_sample;
      end else if (w_sample) begin
        r_sampled <= 1'b1;
      end
    end
  end

  seg7_to_bcd u_dec (
    .i_pat   (w_pat),
    .o_valid (w_pat_ok),
    .o_val   (w_val)
  );

  assign w_multi = (w_strb & (w_strb - 4'd1)) != 4'd0;
  assign w_is_a1 = (w_strb == 4'b0001);
  assign w_idx   = strb_index(w_strb);

  // Stage: frame assembly and output registers
  always_ff @(posedge clk) begin
    if (clr) begin
      r_state     <= HUNT;
      r_k         <= 2'd0;
      dig0        <= 4'd0;
      dig1        <= 4'd0;
      dig2        <= 4'd0;
      dig3        <= 4'd0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      err_code    <= ERR_NONE;
      if (w_sample) begin
        if (w_multi) begin
          frame_err <= 1'b1;
          err_code  <= ERR_MULTI;
          r_state   <= HUNT;
        end else if (r_state == HUNT) begin
          if (w_is_a1 && w_pat_ok) begin
            r_shadow[0] <= w_val;
            r_k         <= 2'd1;
            r_state     <= CAP;
          end
        end else if (w_pat_ok && (w_idx == r_k)) begin
          r_shadow[r_k] <= w_val;
          if (r_k == 2'd3) begin
            dig0        <= r_shadow[0];
            dig1        <= r_shadow[1];
            dig2        <= r_shadow[2];
            dig3        <= w_val;
            frame_valid <= 1'b1;
            r_state     <= HUNT;
          end else begin
            r_k <= r_k + 2'd1;
          end
        end else begin
          frame_err <= 1'b1;
          err_code  <= w_pat_ok ? ERR_ORDER : ERR_PATTERN;
          // A well-formed A1 that broke the old frame starts the next one
          if (w_is_a1 && w_pat_ok) begin
            r_shadow[0] <= w_val;
            r_k         <= 2'd1;
            r_state     <= CAP;
          end else begin
            r_state <= HUNT;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_rx.sv
// Bench for seg7_scan_rx: scenario tasks plus a randomised run, all checked
// against a frame-level model of the scanned display protocol.
module tb_seg7_scan_rx;

  localparam int SYNC   = 2;
  localparam int SETTLE = 3;
  localparam logic [6:0] BLANK = 7'h7F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       sa = 1'b1, sb = 1'b1, sc = 1'b1, sd = 1'b1, se = 1'b1, sf = 1'b1, sg = 1'b1;
  logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0, s4 = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic       frame_valid, frame_err;
  logic [1:0] err_code;

  seg7_scan_rx #(.SYNC_STAGES(SYNC), .SETTLE(SETTLE)) dut (
    .clk(clk), .clr(clr),
    .a(sa), .b(sb), .c(sc), .d(sd), .e(se), .f(sf), .g(sg),
    .A1(s1), .A2(s2), .A3(s3), .A4(s4),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code)
  );

  typedef struct packed {
    logic        fv;
    logic        fe;
    logic [1:0]  code;
    logic [15:0] dig;
  } obs_t;

  int total = 0;
  int bad   = 0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  // Pin history and observation logs
  logic [3:0] hist_s [$];
  logic [6:0] hist_p [$];
  logic       hist_r [$];
  obs_t       lg_obs [$];
  obs_t       lg_exp [$];

  // Protocol model state
  logic [3:0]  m_prev = 4'd0;
  logic [3:0]  m_dw   = 4'd0;
  int          m_rc   = 0;
  bit          m_ds   = 1'b0;
  int          got [$];
  logic [15:0] m_dig  = 16'h0;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  // One clock of stimulus; the model predicts the outputs after this edge.
  task automatic tick(input logic r, input logic [3:0] s, input logic [6:0] p);
    obs_t o, x;
    logic [3:0] vs;
    logic [6:0] vp;
    bit win, smp;
    int ed, v;
    clr = r;
    {s4, s3, s2, s1} = s;
    {sg, sf, se, sd, sc, sb, sa} = p;
    @(posedge clk);
    hist_s.push_back(s); hist_p.push_back(p); hist_r.push_back(r);
    ed = hist_r.size() - 1;
    x.fv = 1'b0; x.fe = 1'b0; x.code = 2'b00;
    if (r) begin
      m_prev = 4'd0; m_dw = 4'd0; m_rc = 0; m_ds = 1'b0; got.delete(); m_dig = 16'h0;
    end else begin
      win = (ed < SYNC);
      for (int k = ed - SYNC; k < ed; k++) if (k >= 0 && hist_r[k]) win = 1'b1;
      vs = 4'd0; vp = BLANK;
      if (!win) begin vs = hist_s[ed-SYNC]; vp = hist_p[ed-SYNC]; end
      if (vs == 4'd0) m_rc = 0;
      else if (vs == m_prev) m_rc = m_rc + 1;
      else begin
        m_rc = 1;
        if (vs != m_dw) begin m_dw = vs; m_ds = 1'b0; end
      end
      m_prev = vs;
      smp = (vs != 4'd0) && (m_rc == SETTLE) && !m_ds;
      if (smp) begin
        m_ds = 1'b1;
        v = lookup(vp);
        if ($countones(vs) > 1) begin
          x.fe = 1'b1; x.code = 2'b11; got.delete();
        end else if (got.size() == 0) begin
          if (vs == 4'b0001 && v >= 0) got.push_back(v);
        end else if (v >= 0 && vs == 4'(1 << got.size())) begin
          got.push_back(v);
          if (got.size() == 4) begin
            m_dig = {4'(got[3]), 4'(got[2]), 4'(got[1]), 4'(got[0])};
            x.fv = 1'b1;
            got.delete();
          end
        end else begin
          x.fe = 1'b1; x.code = (v < 0) ? 2'b01 : 2'b10;
          got.delete();
          if (vs == 4'b0001 && v >= 0) got.push_back(v);
        end
      end
    end
    x.dig = m_dig;
    #1;
    o.fv = frame_valid; o.fe = frame_err; o.code = err_code;
    o.dig = {dig3, dig2, dig1, dig0};
    lg_obs.push_back(o); lg_exp.push_back(x);
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [6:0] p, input int len);
    repeat (len) tick(r, s, p);
  endtask

  task automatic scan(input int d0, input int d1, input int d2, input int d3, input int hold);
    step(1'b0, 4'b0001, seg_tab[d0], hold);
    step(1'b0, 4'b0010, seg_tab[d1], hold);
    step(1'b0, 4'b0100, seg_tab[d2], hold);
    step(1'b0, 4'b1000, seg_tab[d3], hold);
  endtask

  task automatic log_clear();
    lg_obs.delete(); lg_exp.delete();
  endtask

  function automatic int count_fv();
    int n = 0;
    foreach (lg_obs[i]) if (lg_obs[i].fv === 1'b1) n++;
    return n;
  endfunction

  function automatic int count_fe();
    int n = 0;
    foreach (lg_obs[i]) if (lg_obs[i].fe === 1'b1) n++;
    return n;
  endfunction

  function automatic logic [1:0] first_code();
    foreach (lg_obs[i]) if (lg_obs[i].fe === 1'b1) return lg_obs[i].code;
    return 2'bxx;
  endfunction

  task automatic test_reset();
    log_clear();
    repeat (2) tick(1'b1, 4'($urandom), 7'($urandom));
    total++;
    if ({dig3, dig2, dig1, dig0} !== 16'h0 || frame_valid !== 1'b0 || frame_err !== 1'b0 || err_code !== 2'b00) begin
      bad++;
      $display("FAIL reset_state got dig=%h fv=%b fe=%b code=%b want 0000/0/0/00",
               {dig3, dig2, dig1, dig0}, frame_valid, frame_err, err_code);
    end
    step(1'b0, 4'b0010, seg_tab[2], 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fv() != 0 || count_fe() != 0) begin
      bad++; $display("FAIL reset_a2_quiet got fv=%0d fe=%0d want 0/0", count_fv(), count_fe());
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL reset_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_clean();
    int t4, f;
    for (int pass = 0; pass < 2; pass++) begin
      log_clear();
      if (pass == 0) begin
        step(1'b0, 4'b0001, 7'h79, 8); step(1'b0, 4'b0010, 7'h24, 8); step(1'b0, 4'b0100, 7'h30, 8);
        t4 = lg_obs.size();
        step(1'b0, 4'b1000, 7'h19, 8);
      end else begin
        step(1'b0, 4'b0001, 7'h40, 8); step(1'b0, 4'b0010, 7'h78, 8); step(1'b0, 4'b0100, 7'h00, 8);
        t4 = lg_obs.size();
        step(1'b0, 4'b1000, 7'h10, 8);
      end
      step(1'b0, 4'b0000, BLANK, 8);
      f = -1;
      for (int i = lg_obs.size() - 1; i >= t4; i--) if (lg_obs[i].fv === 1'b1) f = i;
      total++;
      if (f < 0 || f - t4 + 1 != SYNC + SETTLE) begin
        bad++; $display("FAIL clean_latency got %0d want %0d", (f < 0) ? -1 : f - t4 + 1, SYNC + SETTLE);
      end
      total++;
      if (count_fv() != 1) begin bad++; $display("FAIL clean_pulses got %0d want 1", count_fv()); end
      total++;
      if ({dig3, dig2, dig1, dig0} !== ((pass == 0) ? 16'h4321 : 16'h9870)) begin
        bad++; $display("FAIL clean_digits got %h want %h", {dig3, dig2, dig1, dig0}, (pass == 0) ? 16'h4321 : 16'h9870);
      end
      for (int i = 0; i < lg_obs.size(); i++) begin
        total++;
        if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
            (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
          bad++;
          $display("FAIL clean_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                   lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                   lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
        end
      end
    end
  endtask

  task automatic test_bad_pattern();
    log_clear();
    step(1'b0, 4'b0001, 7'h12, 8);
    step(1'b0, 4'b0010, 7'h7F, 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fe() != 1 || first_code() !== 2'b01) begin
      bad++; $display("FAIL badpat_err got n=%0d code=%b want 1/01", count_fe(), first_code());
    end
    total++;
    if ({dig3, dig2, dig1, dig0} !== 16'h9870) begin
      bad++; $display("FAIL badpat_hold got %h want 9870", {dig3, dig2, dig1, dig0});
    end
    scan(5, 6, 7, 8, 6);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if ({dig3, dig2, dig1, dig0} !== 16'h8765 || count_fv() != 1) begin
      bad++; $display("FAIL badpat_recover got %h/%0d want 8765/1", {dig3, dig2, dig1, dig0}, count_fv());
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL badpat_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_order_glitch();
    log_clear();
    step(1'b0, 4'b0001, seg_tab[3], 8);
    step(1'b0, 4'b0100, seg_tab[3], 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fe() != 1 || first_code() !== 2'b10 || {dig3, dig2, dig1, dig0} !== 16'h8765) begin
      bad++; $display("FAIL order_err got n=%0d code=%b dig=%h want 1/10/8765", count_fe(), first_code(), {dig3, dig2, dig1, dig0});
    end
    scan(2, 4, 6, 8, 5);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if ({dig3, dig2, dig1, dig0} !== 16'h8642) begin
      bad++; $display("FAIL order_recover got %h want 8642", {dig3, dig2, dig1, dig0});
    end
    log_clear();
    step(1'b0, 4'b0001, seg_tab[1], 8);
    step(1'b0, 4'b0100, seg_tab[9], SETTLE - 1);
    step(1'b0, 4'b0010, seg_tab[1], 8);
    step(1'b0, 4'b0100, seg_tab[1], 8);
    step(1'b0, 4'b1000, seg_tab[1], 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fe() != 0 || count_fv() != 1 || {dig3, dig2, dig1, dig0} !== 16'h1111) begin
      bad++; $display("FAIL glitch got fe=%0d fv=%0d dig=%h want 0/1/1111", count_fe(), count_fv(), {dig3, dig2, dig1, dig0});
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL glitch_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_multi_blank();
    log_clear();
    step(1'b0, 4'b0011, seg_tab[0], SETTLE);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fe() != 1 || first_code() !== 2'b11) begin
      bad++; $display("FAIL multi_err got n=%0d code=%b want 1/11", count_fe(), first_code());
    end
    log_clear();
    step(1'b0, 4'b0001, seg_tab[7], 8);
    step(1'b0, 4'b0000, BLANK, 5);
    step(1'b0, 4'b0001, seg_tab[7], 8);
    step(1'b0, 4'b0010, seg_tab[3], 8);
    step(1'b0, 4'b0100, seg_tab[0], 8);
    step(1'b0, 4'b1000, seg_tab[2], 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fe() != 0 || count_fv() != 1 || {dig3, dig2, dig1, dig0} !== 16'h2037) begin
      bad++; $display("FAIL blank_dwell got fe=%0d fv=%0d dig=%h want 0/1/2037", count_fe(), count_fv(), {dig3, dig2, dig1, dig0});
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL blank_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_reset_mid();
    log_clear();
    step(1'b0, 4'b0001, seg_tab[9], 8);
    step(1'b0, 4'b0010, seg_tab[8], 8);
    step(1'b0, 4'b0100, seg_tab[7], 4);
    step(1'b1, 4'b0100, seg_tab[7], 1);
    step(1'b0, 4'b0100, seg_tab[7], 4);
    step(1'b0, 4'b1000, seg_tab[6], 8);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fv() != 0 || {dig3, dig2, dig1, dig0} !== 16'h0) begin
      bad++; $display("FAIL midreset got fv=%0d dig=%h want 0/0000", count_fv(), {dig3, dig2, dig1, dig0});
    end
    scan(4, 3, 2, 1, 6);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if ({dig3, dig2, dig1, dig0} !== 16'h1234 || count_fv() != 1) begin
      bad++; $display("FAIL midreset_next got %h/%0d want 1234/1", {dig3, dig2, dig1, dig0}, count_fv());
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL midreset_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_back_to_back();
    log_clear();
    scan(3, 1, 4, 1, SETTLE + 1);
    scan(5, 9, 2, 6, SETTLE + 1);
    step(1'b0, 4'b0000, BLANK, 8);
    total++;
    if (count_fv() != 2 || count_fe() != 0 || {dig3, dig2, dig1, dig0} !== 16'h6295) begin
      bad++; $display("FAIL b2b got fv=%0d fe=%0d dig=%h want 2/0/6295", count_fv(), count_fe(), {dig3, dig2, dig1, dig0});
    end
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code)) begin
        bad++;
        $display("FAIL b2b_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] s;
    logic [6:0] p;
    int r;
    log_clear();
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < 4; k++) begin
        s = 4'(1 << k);
        p = seg_tab[$urandom_range(0, 9)];
        r = $urandom_range(0, 15);
        if (r == 0) p = 7'($urandom);
        if (r == 1) s = 4'($urandom_range(1, 15));
        if (r == 2) step(1'b0, 4'b0000, BLANK, $urandom_range(1, 4));
        step(1'b0, s, p, $urandom_range(SETTLE - 1, 8));
      end
      step(1'b0, 4'b0000, BLANK, $urandom_range(0, 6));
    end
    step(1'b0, 4'b0000, BLANK, 10);
    for (int i = 0; i < lg_obs.size(); i++) begin
      total++;
      if (lg_obs[i].fv !== lg_exp[i].fv || lg_obs[i].fe !== lg_exp[i].fe || lg_obs[i].dig !== lg_exp[i].dig ||
          (lg_exp[i].fe && lg_obs[i].code !== lg_exp[i].code) || (lg_obs[i].fv && lg_obs[i].fe)) begin
        bad++;
        $display("FAIL rand_cyc%0d got fv=%b fe=%b code=%b dig=%h want fv=%b fe=%b code=%b dig=%h", i,
                 lg_obs[i].fv, lg_obs[i].fe, lg_obs[i].code, lg_obs[i].dig,
                 lg_exp[i].fv, lg_exp[i].fe, lg_exp[i].code, lg_exp[i].dig);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bad_pattern();
    test_order_glitch();
    test_multi_blank();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
